// File: rtl/ifu_fetch_if.sv
// Fetch-unit bundle: redirect from execute, instruction-memory request/response,
// and the decoder-facing instruction handshake.
interface ifu_fetch_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        misalign;

   modport master (
      input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
             imem_rsp_data, inst_ready,
      output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, misalign
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
             imem_rsp_data, inst_ready,
      input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, misalign
   );
endinterface

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch FSM: REQ -> WAIT -> OUT, with redirect handling.
// Define IFU_MISALIGN_EN to trap misaligned redirects in a sticky ERR state.
//
//   state | meaning
//   REQ   | issue a request for pc (held off while a dropped response is still due)
//   WAIT  | request accepted, waiting for its response
//   OUT   | instruction presented to the decoder
//   ERR   | misaligned redirect seen, fetch halted until reset
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic         clk,
   input  logic         rst,
   ifu_fetch_if.master  bus
);

   typedef enum logic [1:0] {REQ, WAIT, OUT, ERR} state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic        drop_q;
   logic [31:0] inst_q;
   logic [31:0] inst_pc_q;

   logic [31:0] redir_tgt;
   logic        redir_bad;
   logic        req_fire;

`ifdef IFU_MISALIGN_EN
   assign redir_tgt = bus.redirect_pc;
   assign redir_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
   assign bus.misalign = (state_q == ERR);
`else
   assign redir_tgt = bus.redirect_pc & 32'hFFFF_FFFC;
   assign redir_bad = 1'b0;
   assign bus.misalign = 1'b0;
`endif

   // A dropped response still in flight blocks new requests, except in the
   // cycle it retires, so at most one request is ever outstanding.
   assign bus.imem_req_valid = !rst && (state_q == REQ) && !bus.redirect_valid
                               && (!drop_q || bus.imem_rsp_valid);
   assign bus.imem_req_addr  = pc_q;
   assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

   assign bus.inst_valid = !rst && (state_q == OUT);
   assign bus.inst       = inst_q;
   assign bus.inst_pc    = inst_pc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= REQ;
         pc_q      <= RESET_PC;
         drop_q    <= 1'b0;
         inst_q    <= 32'h0;
         inst_pc_q <= 32'h0;
      end else begin
         unique case (state_q)
            REQ: begin
               if (drop_q && bus.imem_rsp_valid)
                  drop_q <= 1'b0;
               if (redir_bad)
                  state_q <= ERR;
               else if (bus.redirect_valid)
                  pc_q <= redir_tgt;
               else if (req_fire)
                  state_q <= WAIT;
            end
            WAIT: begin
               if (redir_bad) begin
                  state_q <= ERR;
               end else if (bus.redirect_valid) begin
                  pc_q    <= redir_tgt;
                  drop_q  <= !bus.imem_rsp_valid;
                  state_q <= REQ;
               end else if (bus.imem_rsp_valid) begin
                  inst_q    <= bus.imem_rsp_data;
                  inst_pc_q <= pc_q;
                  state_q   <= OUT;
               end
            end
            OUT: begin
               if (redir_bad) begin
                  state_q <= ERR;
               end else if (bus.redirect_valid) begin
                  pc_q    <= redir_tgt;
                  state_q <= REQ;
               end else if (bus.inst_ready) begin
                  pc_q    <= pc_q + 32'd4;
                  state_q <= REQ;
               end
            end
            ERR: state_q <= ERR;
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed scenarios followed by a randomized run checked against a
// transaction-level model of the fetch unit.
module tb_ifu_fetch;
   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ifu_fetch_if bus();

   ifu_fetch #(.RESET_PC(RST_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic idle_inputs();
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
      bus.inst_ready     = 1'b0;
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // reference model state
   logic [31:0] m_pc, m_paddr, m_ipc, tgt;
   bit          m_out, m_stale, m_pres;
   bit          redir, rsp_now, exp_req, acc, hs;

   initial begin
      idle_inputs();
      rst = 1'b1;

      // reset state
      tick(); tick();
      settle();
      check_eq("rst_req_valid", bus.imem_req_valid, 0);
      check_eq("rst_inst_valid", bus.inst_valid, 0);
      check_eq("rst_inst", bus.inst, 0);
      check_eq("rst_inst_pc", bus.inst_pc, 0);
      check_eq("rst_misalign", bus.misalign, 0);

      // first fetch after reset
      tick(); rst = 1'b0; bus.imem_req_ready = 1'b1; settle();
      check_eq("first_req_valid", bus.imem_req_valid, 1);
      check_eq("first_req_addr", bus.imem_req_addr, RST_PC);
      tick(); bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0013; settle();
      check_eq("wait_req_valid", bus.imem_req_valid, 0);
      check_eq("wait_inst_valid", bus.inst_valid, 0);
      tick(); bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0; settle();
      check_eq("out_inst_valid", bus.inst_valid, 1);
      check_eq("out_inst", bus.inst, 32'h0000_0013);
      check_eq("out_inst_pc", bus.inst_pc, RST_PC);

      // decoder stall: output held, no new request
      for (int i = 0; i < 5; i++) begin
         tick(); settle();
         check_eq("stall_inst_valid", bus.inst_valid, 1);
         check_eq("stall_inst", bus.inst, 32'h0000_0013);
         check_eq("stall_inst_pc", bus.inst_pc, RST_PC);
         check_eq("stall_req_valid", bus.imem_req_valid, 0);
      end
      tick(); bus.inst_ready = 1'b1; settle();
      tick(); bus.inst_ready = 1'b0; bus.imem_req_ready = 1'b1; settle();
      check_eq("next_req_valid", bus.imem_req_valid, 1);
      check_eq("next_req_addr", bus.imem_req_addr, RST_PC + 32'd4);

      // redirect in WAIT, stale response next cycle
      tick(); bus.imem_req_ready = 1'b0;
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0100; settle();
      check_eq("redir_wait_req_valid", bus.imem_req_valid, 0);
      tick(); bus.redirect_valid = 1'b0;
      bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF;
      bus.imem_req_ready = 1'b1; settle();
      check_eq("redir_req_valid", bus.imem_req_valid, 1);
      check_eq("redir_req_addr", bus.imem_req_addr, 32'h8000_0100);
      tick(); bus.imem_rsp_valid = 1'b0; bus.imem_req_ready = 1'b0; settle();
      check_eq("stale_not_shown", bus.inst_valid, 0);
      tick(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h1111_1111; settle();
      check_eq("stale_not_shown2", bus.inst_valid, 0);
      tick(); bus.imem_rsp_valid = 1'b0; settle();
      check_eq("redir_inst_valid", bus.inst_valid, 1);
      check_eq("redir_inst", bus.inst, 32'h1111_1111);
      check_eq("redir_inst_pc", bus.inst_pc, 32'h8000_0100);

      // redirect in OUT coincident with consume
      tick(); bus.inst_ready = 1'b1;
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0200; settle();
      check_eq("out_redir_req_valid", bus.imem_req_valid, 0);
      tick(); bus.inst_ready = 1'b0; bus.redirect_valid = 1'b0;
      bus.imem_req_ready = 1'b1; settle();
      check_eq("out_redir_inst_valid", bus.inst_valid, 0);
      check_eq("out_redir_req_addr", bus.imem_req_addr, 32'h8000_0200);

      // misaligned redirect while waiting
      tick(); bus.imem_req_ready = 1'b0;
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0102; settle();
      tick(); bus.redirect_valid = 1'b0;
      bus.imem_rsp_valid = 1'b1; bus.imem_req_ready = 1'b1; settle();
`ifdef IFU_MISALIGN_EN
      for (int i = 0; i < 4; i++) begin
         check_eq("err_misalign", bus.misalign, 1);
         check_eq("err_req_valid", bus.imem_req_valid, 0);
         check_eq("err_inst_valid", bus.inst_valid, 0);
         tick(); bus.imem_rsp_valid = 1'b0; settle();
      end
`else
      check_eq("mis_req_valid", bus.imem_req_valid, 1);
      check_eq("mis_req_addr", bus.imem_req_addr, 32'h8000_0100);
      check_eq("mis_misalign", bus.misalign, 0);
`endif

      // reset mid-transaction with responses during and right after reset
      tick(); rst = 1'b1; bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b1; settle();
      check_eq("rst_mid_req_valid", bus.imem_req_valid, 0);
      check_eq("rst_mid_inst_valid", bus.inst_valid, 0);
      tick(); settle();
      check_eq("rst_mid_misalign", bus.misalign, 0);
      check_eq("rst_mid_inst_pc", bus.inst_pc, 0);
      tick(); rst = 1'b0; settle();
      check_eq("post_rst_req_valid", bus.imem_req_valid, 1);
      check_eq("post_rst_req_addr", bus.imem_req_addr, RST_PC);
      tick(); bus.imem_rsp_valid = 1'b0; settle();
      check_eq("post_rst_discard", bus.inst_valid, 0);

      // randomized run against the transaction-level model
      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      m_pc = RST_PC; m_paddr = 32'h0; m_ipc = 32'h0;
      m_out = 0; m_stale = 0; m_pres = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c != 0) tick();
         redir = ($urandom % 10) == 0;
         case ($urandom % 4)
            0:       tgt = 32'hFFFF_FFFC - 32'd4 * ($urandom % 3);
            1:       tgt = $urandom;
            default: tgt = RST_PC + ($urandom % 64);
         endcase
`ifdef IFU_MISALIGN_EN
         tgt = tgt & 32'hFFFF_FFFC;
`endif
         rsp_now = m_out && ($urandom % 2 == 0);
         bus.redirect_valid = redir;
         bus.redirect_pc    = tgt;
         bus.imem_req_ready = ($urandom % 3) != 0;
         bus.imem_rsp_valid = rsp_now;
         bus.imem_rsp_data  = rsp_now ? mem_word(m_paddr) : $urandom;
         bus.inst_ready     = ($urandom % 3) != 0;
         settle();

         exp_req = !redir && !m_pres && (!m_out || (m_stale && rsp_now));
         check_eq("rnd_req_valid", bus.imem_req_valid, exp_req);
         if (exp_req) check_eq("rnd_req_addr", bus.imem_req_addr, m_pc);
         check_eq("rnd_inst_valid", bus.inst_valid, m_pres);
         if (m_pres) begin
            check_eq("rnd_inst", bus.inst, mem_word(m_ipc));
            check_eq("rnd_inst_pc", bus.inst_pc, m_ipc);
         end
         check_eq("rnd_misalign", bus.misalign, 0);

         acc = exp_req && bus.imem_req_ready;
         hs  = m_pres && bus.inst_ready;
         if (rsp_now) begin
            m_out = 0;
            if (!m_stale) begin
               m_pres = 1;
               m_ipc  = m_paddr;
            end
         end
         if (redir) begin
            m_pc   = tgt & 32'hFFFF_FFFC;
            m_pres = 0;
            if (m_out) m_stale = 1;
         end else begin
            if (hs) begin
               m_pres = 0;
               m_pc   = m_pc + 32'd4;
            end
            if (acc) begin
               m_out   = 1;
               m_stale = 0;
               m_paddr = m_pc;
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
